alu_ctrl_pipe: RTL and testbench
================================

# alu_ctrl_pipe

Registered, handshaked ALU control decoder sitting between the decode and execute stages of the pipelined processor. Each cycle it accepts one instruction (opcode, ra sub-function, tag), decodes it into ALU control code and operand-select strobes, and holds the result in an output register under a valid/ready handshake. It adds stall and flush handling and a two-micro-op RTI sequence, and generalises opcode, sub-field, control and tag widths.

## Interface
- OP_W, 4, opcode width (>=4)
- RA_W, 2, ra sub-function field width (>=2)
- CTRL_W, 4, ALU control width (>=4; codes zero-extended)
- TAG_W, 4, opaque tag carried with each instruction

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  block accepts instruction this cycle
- in_op  in  OP_W  opcode
- in_ra  in  RA_W  sub-function field
- in_tag  in  TAG_W  instruction tag
- flush  in  1  discard held and in-flight work
- out_valid  out  1  output register holds a micro-op
- out_ready  in  1  execute stage consumes micro-op
- out_ctrl  out  CTRL_W  ALU control code
- out_se1, out_se2  out  1 each  operand-select strobes
- out_se3  out  2  forwarding select
- out_tag  out  TAG_W  tag of owning instruction
- out_last  out  1  final micro-op of the instruction
- out_illegal  out  1  undefined opcode/sub-function

## Operation
- Decode (op, ra -> ctrl, se1, se2, se3; unlisted strobes 0): 1 MOV -> 1, se3=2; 2 ADD -> 2,1,1; 3 SUB -> 3,1,1; 4 AND -> 4,1,1; 5 OR -> 5,1,1; 6 ra0 RLC -> 6,se2; ra1 RRC -> 7,se2; ra2 SETC -> 8; ra3 CLRC -> 9; 7 POP -> 2; 8 ra0 NOT -> A; ra1 NEG -> B; ra2 INC -> C; ra3 DEC -> D (all se2=1); 10 LOOP -> 3,se1; 11 ra2 RET -> 2,se1; 11 ra3 RTI -> two micro-ops (below).
- Only low 2 bits of ra decoded; any nonzero bit of in_op above bit 3 or in_ra above bit 1 -> illegal.
- Illegal (op 0, 9, 12-15, op 11 with ra 0/1, or upper bits set): ctrl 0, strobes 0, out_illegal=1, out_last=1; still handshaked normally.
- FSM: IDLE, RTI2.
  - IDLE: accept when in_valid && in_ready; load decoded micro-op, out_valid=1. RTI loads micro-op 1 (ctrl 2, se1=1, out_last=0) and moves to RTI2.
  - RTI2: in_ready=0; on out_valid && out_ready load micro-op 2 (ctrl 4'hE flag restore, strobes 0, out_last=1, same tag), return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush (combinational).
- flush: next edge out_valid=0, state=IDLE; any same-cycle input not accepted.

## Timing
- Reset: out_valid 0, out_ctrl/se1/se2/se3/tag/last/illegal 0, state IDLE, in_ready 1 once rst high.
- Latency 1 cycle accept -> out_valid.
- Throughput 1 instr/cycle with out_ready held high; RTI occupies 2 output cycles.
- Output fields stable while out_valid && !out_ready.
- Simultaneous out handshake and input accept: new micro-op replaces old on the same edge, no bubble.
- Flush beats accept and RTI2 advance in same cycle.
- Reset mid-RTI: immediately IDLE, micro-op 2 never issued.

## Configuration
- ALU_CTRL_PERF_EN defined: extra port op_count out 16, counts handshakes with out_last=1 and out_illegal=0; saturates at 16'hFFFF; cleared only by rst, not flush.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then op 2, ra 0, tag 5, out_ready=1 -> next cycle out_valid=1, ctrl 2, se1=se2=1, tag 5, last 1.
- Back-to-back ops 3,4,5 with out_ready=1 -> ctrl 3,4,5 on consecutive cycles, in_ready constantly 1.
- op 11 ra 3 tag 9, out_ready stalled 2 cycles then 1 -> micro-op ctrl 2/last 0 held, then ctrl E/last 1 tag 9; in_ready 0 until micro-op 2 consumed.
- op 9 -> out_illegal=1, ctrl 0, last 1; op 11 ra 0 likewise.
- flush asserted during RTI2 with in_valid=1 -> out_valid 0 next cycle, state IDLE, input not accepted; perf count unchanged (with ALU_CTRL_PERF_EN).
- ALU_CTRL_PERF_EN: 65540 legal ops -> op_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder between decode and execute, with flush and two-micro-op RTI.
// Optional ALU_CTRL_PERF_EN adds a saturating op_count of completed legal instructions.
module alu_ctrl_pipe #(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RA_W   = 2,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RA_W-1:0]   in_ra,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_se1,
  output logic              out_se2,
  output logic [1:0]        out_se3,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_last,
  output logic              out_illegal
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [15:0]       op_count
`endif
);

  typedef enum logic {IDLE, RTI2} state_t;

  state_t     state;
  logic [3:0] op_lo;
  logic [1:0] ra_lo;
  logic       hi_bits;
  logic [3:0] d_ctrl;
  logic       d_se1;
  logic       d_se2;
  logic [1:0] d_se3;
  logic       d_ill;
  logic       d_rti;
  logic       accept;
  logic       out_hs;

  assign op_lo   = in_op[3:0];
  assign ra_lo   = in_ra[1:0];
  assign hi_bits = ((in_op >> 4) != '0) || ((in_ra >> 2) != '0);

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Opcode / sub-function decode; illegal encodings collapse to an all-zero control word.
  always_comb begin
    d_ctrl = 4'h0;
    d_se1  = 1'b0;
    d_se2  = 1'b0;
    d_se3  = 2'd0;
    d_ill  = 1'b0;
    d_rti  = 1'b0;
    case (op_lo)
      4'd1: begin
        d_ctrl = 4'h1;
        d_se3  = 2'd2;
      end
      4'd2, 4'd3, 4'd4, 4'd5: begin
        d_ctrl = op_lo;
        d_se1  = 1'b1;
        d_se2  = 1'b1;
      end
      4'd6: begin
        d_ctrl = 4'h6 + {2'b00, ra_lo};
        d_se2  = ~ra_lo[1];
      end
      4'd7: d_ctrl = 4'h2;
      4'd8: begin
        d_ctrl = 4'hA + {2'b00, ra_lo};
        d_se2  = 1'b1;
      end
      4'd10: begin
        d_ctrl = 4'h3;
        d_se1  = 1'b1;
      end
      4'd11: begin
        case (ra_lo)
          2'd2: begin
            d_ctrl = 4'h2;
            d_se1  = 1'b1;
          end
          2'd3: begin
            d_ctrl = 4'h2;
            d_se1  = 1'b1;
            d_rti  = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (hi_bits) begin
      d_ill = 1'b1;
    end
    if (d_ill) begin
      d_ctrl = 4'h0;
      d_se1  = 1'b0;
      d_se2  = 1'b0;
      d_se3  = 2'd0;
      d_rti  = 1'b0;
    end
  end

  // Control FSM and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_se1     <= 1'b0;
      out_se2     <= 1'b0;
      out_se3     <= 2'd0;
      out_tag     <= '0;
      out_last    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        RTI2: begin
          // Second RTI micro-op: flag restore, same tag.
          if (out_hs) begin
            out_ctrl    <= CTRL_W'(4'hE);
            out_se1     <= 1'b0;
            out_se2     <= 1'b0;
            out_se3     <= 2'd0;
            out_last    <= 1'b1;
            out_illegal <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            out_valid   <= 1'b1;
            out_ctrl    <= CTRL_W'(d_ctrl);
            out_se1     <= d_se1;
            out_se2     <= d_se2;
            out_se3     <= d_se3;
            out_tag     <= in_tag;
            out_last    <= ~d_rti;
            out_illegal <= d_ill;
            state       <= d_rti ? RTI2 : IDLE;
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_EN
  // Completed legal instructions; a flushed cycle does not count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count <= 16'h0000;
    end else if (out_hs && out_last && !out_illegal && !flush && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed table, hand sequences for RTI/flush/reset, and random traffic vs a queue model.
module tb_alu_ctrl_pipe;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_op = '0;
  logic [RA_W-1:0]   in_ra = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_se1;
  logic              out_se2;
  logic [1:0]        out_se3;
  logic [TAG_W-1:0]  out_tag;
  logic              out_last;
  logic              out_illegal;
`ifdef ALU_CTRL_PERF_EN
  logic [15:0]       op_count;
  int                cnt_exp = 0;
`endif

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.OP_W(OP_W), .RA_W(RA_W), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ra(in_ra), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_se1(out_se1), .out_se2(out_se2), .out_se3(out_se3),
    .out_tag(out_tag), .out_last(out_last), .out_illegal(out_illegal)
`ifdef ALU_CTRL_PERF_EN
    , .op_count(op_count)
`endif
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              se1;
    logic              se2;
    logic [1:0]        se3;
    logic [TAG_W-1:0]  tag;
    logic              last;
    logic              illegal;
  } uop_t;

  typedef struct {
    int unsigned op;
    int unsigned ra;
    int unsigned ctrl;
    bit          se1;
    bit          se2;
    int unsigned se3;
    bit          ill;
  } vec_t;

  uop_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected micro-op(s) for one accepted instruction, from the instruction-set rules.
  function automatic void push_expected(input int unsigned o, input int unsigned r, input logic [TAG_W-1:0] tag);
    uop_t u;
    bit   ok;
    u = '0;
    u.tag = tag;
    u.last = 1'b1;
    ok = 1'b1;
    if (o > 15 || r > 3) ok = 1'b0;
    else begin
      case (o)
        1: begin u.ctrl = CTRL_W'(1); u.se3 = 2'd2; end
        2, 3, 4, 5: begin u.ctrl = CTRL_W'(o); u.se1 = 1'b1; u.se2 = 1'b1; end
        6: begin u.ctrl = CTRL_W'(6 + r); u.se2 = (r < 2) ? 1'b1 : 1'b0; end
        7: u.ctrl = CTRL_W'(2);
        8: begin u.ctrl = CTRL_W'(10 + r); u.se2 = 1'b1; end
        10: begin u.ctrl = CTRL_W'(3); u.se1 = 1'b1; end
        11: begin
          if (r == 2) begin
            u.ctrl = CTRL_W'(2); u.se1 = 1'b1;
          end else if (r == 3) begin
            u.ctrl = CTRL_W'(2); u.se1 = 1'b1; u.last = 1'b0;
            q.push_back(u);
            u = '0; u.ctrl = CTRL_W'(14); u.tag = tag; u.last = 1'b1;
          end else ok = 1'b0;
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      u = '0; u.tag = tag; u.last = 1'b1; u.illegal = 1'b1;
    end
    q.push_back(u);
  endfunction

  // One clock cycle: drive inputs, check against the model before the edge, then advance the model.
  task automatic step(input logic v, input int unsigned op, input int unsigned ra, input int unsigned tag,
                      input logic fl, input logic ordy);
    bit   exp_rdy, hs, acc;
    uop_t got;
    @(negedge clk);
    in_valid = v; in_op = OP_W'(op); in_ra = RA_W'(ra); in_tag = TAG_W'(tag);
    flush = fl; out_ready = ordy;
    #1;
    exp_rdy = (q.size() <= 1) && (q.size() == 0 || ordy) && !fl;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      got = '{out_ctrl, out_se1, out_se2, out_se3, out_tag, out_last, out_illegal};
      chk("out_uop", 32'(got), 32'(q[0]));
    end
`ifdef ALU_CTRL_PERF_EN
    chk("op_count", 32'(op_count), 32'(cnt_exp));
`endif
    hs  = (q.size() > 0) && ordy;
    acc = v && exp_rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
`ifdef ALU_CTRL_PERF_EN
      if (hs && q[0].last && !q[0].illegal && cnt_exp < 65535) cnt_exp++;
`endif
      if (hs) void'(q.pop_front());
      if (acc) push_expected(op, ra, TAG_W'(tag));
    end
  endtask

  task automatic chk_out(input string name, input vec_t e, input int unsigned tag, input bit last);
    #1;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_ctrl"}, 32'(out_ctrl), 32'(e.ctrl));
    chk({name, "_se"}, {29'd0, out_se1, out_se2, out_se3 == 2'(e.se3)}, {29'd0, e.se1, e.se2, 1'b1});
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    chk({name, "_last_ill"}, {30'd0, out_last, out_illegal}, {30'd0, last, e.ill});
  endtask

  vec_t tbl[$];
  vec_t e;

  initial begin
    // op, ra, ctrl, se1, se2, se3, illegal
    tbl = '{
      '{2, 0, 2, 1, 1, 0, 0}, '{3, 1, 3, 1, 1, 0, 0}, '{4, 2, 4, 1, 1, 0, 0}, '{5, 3, 5, 1, 1, 0, 0},
      '{1, 0, 1, 0, 0, 2, 0}, '{6, 0, 6, 0, 1, 0, 0}, '{6, 1, 7, 0, 1, 0, 0}, '{6, 2, 8, 0, 0, 0, 0},
      '{6, 3, 9, 0, 0, 0, 0}, '{7, 1, 2, 0, 0, 0, 0}, '{8, 0, 10, 0, 1, 0, 0}, '{8, 3, 13, 0, 1, 0, 0},
      '{10, 0, 3, 1, 0, 0, 0}, '{11, 2, 2, 1, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 1}, '{11, 0, 0, 0, 0, 0, 1},
      '{11, 1, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 1}, '{15, 2, 0, 0, 0, 0, 1}, '{18, 0, 0, 0, 0, 0, 1},
      '{2, 4, 0, 0, 0, 0, 1}
    };

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", {out_ctrl, out_se1, out_se2, out_se3, out_tag, out_last, out_illegal}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with out_ready high.
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].op, tbl[i].ra, (i + 5) % 16, 1'b0, 1'b1);
      chk_out("tbl", tbl[i], (i + 5) % 16, 1'b1);
    end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // RTI with a stalled consumer, a blocked input, then micro-op 2.
    step(1'b1, 11, 3, 9, 1'b0, 1'b0);
    e = '{11, 3, 2, 1, 0, 0, 0};
    chk_out("rti1", e, 9, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 2, 0, 3, 1'b0, 1'b0);
    step(1'b1, 2, 0, 3, 1'b0, 1'b1);
    e = '{11, 3, 14, 0, 0, 0, 0};
    chk_out("rti2", e, 9, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Flush during RTI2 with a pending input.
    step(1'b1, 11, 3, 2, 1'b0, 1'b1);
    step(1'b1, 2, 0, 4, 1'b1, 1'b1);
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 3, 0, 6, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of RTI: micro-op 2 never appears.
    step(1'b1, 11, 3, 7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ctrl", 32'(out_ctrl), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
`ifdef ALU_CTRL_PERF_EN
    cnt_exp = 0;
`endif
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      int unsigned op, ra;
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 15);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, op, ra, $urandom_range(0, 15),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

`ifdef ALU_CTRL_PERF_EN
    for (int i = 0; i < 65540; i++) step(1'b1, 2, 0, 1, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    #1;
    chk("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
